// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage: PC, single outstanding imem request, one-entry decode slot
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [31:0] ImemAddr,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  input  logic        PCSrc,
  input  logic [31:0] PCE,
  input  logic [31:0] ImmOp,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam logic ST_REQ  = 1'b0;
  localparam logic ST_WAIT = 1'b1;

  logic        state;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        drop;
  logic        slot_free;
  logic        req_fire;
  logic        resp_load;
  logic [31:0] redirect_pc;

  assign slot_free    = !InstrValid || InstrReady;
  assign ImemReqValid = rst_n && (state == ST_REQ) && slot_free && !PCSrc;
  assign ImemAddr     = pc;
  assign req_fire     = ImemReqValid && ImemReqReady;
  assign resp_load    = (state == ST_WAIT) && ImemRespValid && !drop && !PCSrc;
  assign redirect_pc  = (PCE + ImmOp) & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      inflight_pc <= RESET_PC;
      drop        <= 1'b0;
    end else begin
      if (PCSrc) begin
        pc <= redirect_pc;
      end else if (req_fire) begin
        pc <= pc + 32'd4;
      end
      if (req_fire) begin
        inflight_pc <= pc;
      end
      if (state == ST_REQ) begin
        if (req_fire) begin
          state <= ST_WAIT;
        end
      end else begin
        // Any response retires the outstanding request; a redirect without one marks it stale.
        if (ImemRespValid) begin
          state <= ST_REQ;
          drop  <= 1'b0;
        end else if (PCSrc) begin
          drop <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrValid <= 1'b0;
      InstrD     <= NOP_INSTR;
      PCD        <= 32'h0;
      PCPlus4D   <= 32'h0;
    end else if (PCSrc) begin
      InstrValid <= 1'b0;
      InstrD     <= NOP_INSTR;
    end else if (resp_load) begin
      InstrValid <= 1'b1;
      InstrD     <= ImemRespData;
      PCD        <= inflight_pc;
      PCPlus4D   <= inflight_pc + 32'd4;
    end else if (InstrValid && InstrReady) begin
      InstrValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage against a transaction-level model
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ImemReqValid;
  logic        ImemReqReady = 1'b0;
  logic [31:0] ImemAddr;
  logic        ImemRespValid = 1'b0;
  logic [31:0] ImemRespData = 32'h0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCE = 32'h0;
  logic [31:0] ImmOp = 32'h0;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemAddr(ImemAddr),
    .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
    .PCSrc(PCSrc), .PCE(PCE), .ImmOp(ImmOp),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // memory model and expected fetch stream
  bit          pending = 0;
  logic [31:0] pend_addr = 32'h0;
  int          cnt = 0;
  int          lat = 1;
  bit          mem_rand = 0;
  bit          dec_rand = 0;
  bit          dec_rdy = 1;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] q[$];
  bit          exp_load = 0;
  logic [31:0] exp_pc = 32'h0;

  // values observed at the last sample point
  bit          s_req = 0, s_acc = 0, s_resp = 0, s_pcsrc = 0, s_valid = 0, s_ready = 0;
  logic [31:0] s_addr = 0, s_pce = 0, s_imm = 0, s_instr = 0, s_pcd = 0;

  task automatic step(input bit pcsrc_i, input logic [31:0] pce_i, input logic [31:0] imm_i);
    bit exp_req;
    bit new_d;
    bit resp;
    PCSrc = pcsrc_i;
    PCE = pce_i;
    ImmOp = imm_i;
    InstrReady = dec_rand ? ($urandom_range(0, 3) != 0) : dec_rdy;
    ImemReqReady = mem_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    resp = 0;
    if (!rst_n) pending = 0;
    else if (pending) begin
      if (cnt == 0) resp = 1;
      else cnt--;
    end
    ImemRespValid = resp;
    ImemRespData = resp ? mem_word(pend_addr) : $urandom();
    #4;
    exp_req = rst_n && !pending && (!InstrValid || InstrReady) && !PCSrc;
    check_eq("req_valid", ImemReqValid, exp_req);
    if (ImemReqValid && exp_req) check_eq("req_addr", ImemAddr, model_pc);
    if (rst_n) begin
      if (s_pcsrc) begin
        check_eq("flush_valid", InstrValid, 0);
        check_eq("flush_nop", InstrD, NOP);
      end else begin
        new_d = InstrValid && (!s_valid || s_ready);
        check_eq("deliver", new_d, exp_load);
        if (new_d && exp_load) begin
          check_eq("pcd", PCD, exp_pc);
          check_eq("instr", InstrD, mem_word(exp_pc));
          check_eq("pcplus4", PCPlus4D, exp_pc + 32'd4);
        end
        if (InstrValid && s_valid && !s_ready) begin
          check_eq("hold_instr", InstrD, s_instr);
          check_eq("hold_pcd", PCD, s_pcd);
        end
      end
    end
    s_req = ImemReqValid;
    s_addr = ImemAddr;
    s_acc = ImemReqValid && ImemReqReady && !pending;
    s_resp = resp;
    s_pcsrc = PCSrc && rst_n;
    s_pce = PCE;
    s_imm = ImmOp;
    s_valid = InstrValid;
    s_ready = InstrReady;
    s_instr = InstrD;
    s_pcd = PCD;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pending = 0;
      q.delete();
      model_pc = RESET_PC;
      exp_load = 0;
    end else begin
      exp_load = s_resp && !s_pcsrc && (q.size() > 0);
      if (exp_load) exp_pc = q.pop_front();
      if (s_resp) pending = 0;
      if (s_pcsrc) begin
        q.delete();
        model_pc = (s_pce + s_imm) & 32'hFFFF_FFFC;
      end else if (s_acc) begin
        q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
        pending = 1;
        pend_addr = s_addr;
        cnt = lat - 1;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0);
  endtask

  task automatic step_until_valid(input string tag);
    for (int n = 0; n < 20; n++) begin
      idle();
      if (s_valid) break;
    end
    check_eq(tag, s_valid, 1);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req_valid", ImemReqValid, 0);
    check_eq("rst_instr_valid", InstrValid, 0);
    check_eq("rst_instr", InstrD, NOP);
    check_eq("rst_pcd", PCD, 32'h0);
    check_eq("rst_pcplus4", PCPlus4D, 32'h0);
  endtask

  initial begin
    logic [31:0] pcd_hold;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) idle();
    check_reset_outputs();

    // boot: ready memory with 1-cycle latency, decode always ready
    lat = 1;
    dec_rdy = 1;
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      idle();
      check_eq("boot_req", s_req, (i % 2 == 0));
      if (i % 2 == 0) check_eq("boot_addr", s_addr, 32'(2 * i));
      check_eq("boot_valid", s_valid, (i >= 2 && i % 2 == 0));
    end

    // decode stall
    dec_rdy = 0;
    step_until_valid("stall_fill");
    pcd_hold = s_pcd;
    for (int i = 0; i < 5; i++) begin
      idle();
      check_eq("stall_req", s_req, 0);
      check_eq("stall_valid", s_valid, 1);
      check_eq("stall_pcd", s_pcd, pcd_hold);
    end
    dec_rdy = 1;
    idle();
    check_eq("resume_req", s_req, 1);
    check_eq("resume_addr", s_addr, pcd_hold + 32'd4);

    // redirect while able to request
    for (int n = 0; n < 10 && pending; n++) idle();
    step(1'b1, 32'h0000_0100, 32'hFFFF_FFF0);
    check_eq("redir_req_blocked", s_req, 0);
    lat = 3;
    idle();
    check_eq("redir_valid", s_valid, 0);
    check_eq("redir_req", s_req, 1);
    check_eq("redir_addr", s_addr, 32'h0000_00F0);

    // redirect while waiting on a slow response
    step(1'b1, 32'h0000_0100, 32'h0000_0100);
    for (int n = 0; n < 12; n++) begin
      idle();
      check_eq("drop_valid", s_valid, 0);
      if (s_req) break;
    end
    check_eq("drop_req", s_req, 1);
    check_eq("drop_addr", s_addr, 32'h0000_0200);
    step_until_valid("drop_fill");
    check_eq("drop_pcd", s_pcd, 32'h0000_0200);

    // redirect in the same cycle as the response
    lat = 2;
    for (int n = 0; n < 20; n++) begin
      if (pending && cnt == 0) break;
      idle();
    end
    check_eq("coinc_found", (pending && cnt == 0), 1);
    step(1'b1, 32'h0000_0300, 32'h0);
    check_eq("coinc_req_blocked", s_req, 0);
    idle();
    check_eq("coinc_req", s_req, 1);
    check_eq("coinc_addr", s_addr, 32'h0000_0300);
    step_until_valid("coinc_fill");
    check_eq("coinc_pcd", s_pcd, 32'h0000_0300);
    check_eq("coinc_instr", s_instr, mem_word(32'h0000_0300));

    // PC wrap, then asynchronous reset while a request is outstanding
    lat = 1;
    for (int n = 0; n < 10 && pending; n++) idle();
    step(1'b1, 32'hFFFF_FFF0, 32'h0000_000C);
    idle();
    check_eq("wrap_req", s_req, 1);
    check_eq("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
    lat = 3;
    for (int n = 0; n < 10; n++) begin
      idle();
      if (s_req) break;
    end
    check_eq("wrap_req_next", s_req, 1);
    check_eq("wrap_addr_zero", s_addr, 32'h0);
    check_eq("wrap_pcd", PCD, 32'hFFFF_FFFC);
    #1;
    rst_n = 0;
    #1;
    check_reset_outputs();
    idle();
    idle();
    rst_n = 1;
    lat = 1;
    idle();
    check_eq("restart_req", s_req, 1);
    check_eq("restart_addr", s_addr, RESET_PC);
    step_until_valid("restart_fill");
    check_eq("restart_pcd", s_pcd, RESET_PC);

    // randomized traffic
    mem_rand = 1;
    dec_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) step(1'b1, $urandom(), $urandom());
      else idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage for the single-issue RV32I core.
- Owns the PC and issues word requests to instruction memory over a valid/ready handshake.
- Holds each returned instruction in a one-entry output slot for decode, which drives the immediate sign extender.
- Consumes the sign-extended immediate (ImmOp) with the branch/jump PC to form redirect targets PCE + ImmOp.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
NOP_INSTR, 32'h0000_0013, value driven on InstrD at reset and after flush (addi x0,x0,0)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ImemReqValid  output  1  fetch request valid
ImemReqReady  input  1  memory accepts request this cycle
ImemAddr  output  32  fetch address (current PC)
ImemRespValid  input  1  response data valid (one per accepted request, >=1 cycle after accept)
ImemRespData  input  32  fetched instruction word
PCSrc  input  1  taken branch/jump redirect from execute, single-cycle pulse
PCE  input  32  PC of the redirecting instruction
ImmOp  input  32  sign-extended B/J immediate for that instruction
InstrValid  output  1  output slot holds a valid instruction
InstrReady  input  1  decode consumes the slot this cycle
InstrD  output  32  instruction to decode
PCD  output  32  PC of InstrD
PCPlus4D  output  32  PCD + 4

Behaviour:
- State machine with two states:
  - REQ: may issue a request.
  - WAIT: one request outstanding. At most one request in flight, ever.
- Registers: PC, InflightPC, Drop flag, output slot (InstrValid, InstrD, PCD, PCPlus4D).
- Reset (async, rst_n=0), also on deassert-free hold:
  - State=REQ, PC=RESET_PC, Drop=0.
  - InstrValid=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
  - ImemReqValid=0 while rst_n=0.
- Reset mid-transaction simply abandons the outstanding request. The memory is reset by the same rst_n.
- SlotFree = !InstrValid || InstrReady.
- ImemReqValid = (State==REQ) && SlotFree && !PCSrc (combinational). ImemAddr = PC.
- Request valid may drop without a handshake. Memory treats each cycle's request independently.
- REQ with ImemReqValid && ImemReqReady:
  - InflightPC<=PC, PC<=PC+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), State<=WAIT.
- WAIT with ImemRespValid, Drop=0 and no PCSrc:
  - Load slot: InstrD<=ImemRespData, PCD<=InflightPC, PCPlus4D<=InflightPC+4, InstrValid<=1.
  - State<=REQ.
- WAIT with ImemRespValid and Drop=1: discard data, Drop<=0, State<=REQ.
- Slot consumption: InstrValid && InstrReady with no new load in the same cycle -> InstrValid<=0. Slot contents are otherwise held stable while InstrValid && !InstrReady.
- Fetch-to-decode latency with single-cycle memory: request accepted cycle N, response N+1, InstrValid high N+2.
- Peak throughput is one instruction per 2 cycles.
- Redirect (PCSrc=1) has highest priority:
  - PC<=(PCE+ImmOp) & 32'hFFFF_FFFC. Bits [1:0] are cleared; no misalignment trap in this stage.
  - InstrValid<=0 and InstrD<=NOP_INSTR, regardless of InstrReady.
  - In REQ: no request is issued that cycle (ImemReqValid forced 0).
  - In WAIT, no response this cycle: Drop<=1, stay WAIT.
  - In WAIT, response this cycle: discard it, State<=REQ, Drop stays 0.
  - Redirect while Drop already 1: Drop stays 1, PC updated to the newest target.
- Back-to-back redirects: the last one wins.
- No instruction fetched from a pre-redirect PC may ever reach InstrValid=1 after the redirect cycle.

Test Plan:
- Reset release with RESET_PC=0, memory ready=1, 1-cycle latency, decode ready=1:
  - Addresses issued 0x0, 0x4, 0x8 on every other cycle.
  - InstrD/PCD pairs match memory contents; PCPlus4D=PCD+4.
  - First InstrValid two cycles after first accept.
- Decode stall: hold InstrReady=0 for 5 cycles with a valid slot:
  - ImemReqValid=0 throughout; InstrD/PCD stable.
  - On InstrReady=1, the request for the next PC issues in the same cycle.
- Redirect in REQ: PCSrc=1, PCE=0x100, ImmOp=0xFFFF_FFF0:
  - No request that cycle; next ImemAddr=0xF0.
  - InstrValid=0 the following cycle.
- Redirect in WAIT with 3-cycle memory latency, target 0x200:
  - Response for the old PC is discarded (InstrValid stays 0).
  - Next ImemAddr=0x200; first delivered PCD=0x200.
- Redirect coincident with response (PCSrc and ImemRespValid in the same WAIT cycle):
  - Data discarded, no Drop left set.
  - Next request to the target; the next response is accepted normally.
- Wrap and async reset: set PC via redirect to 0xFFFF_FFFC:
  - Next issued address is 0x0.
  - Assert rst_n=0 mid-WAIT: outputs immediately at reset values; after release fetch restarts at RESET_PC.
